bus_xfer_ctrl: RTL and testbench

Register-to-register transfer sequencer for the shared 8-bit data bus. It accepts transfer requests (source register index, destination register index) through a valid/ready handshake and buffers them in a 2-entry queue. Each request is executed by driving exactly one source register's tri-state output enable and then pulsing the destination register's load. It sits directly upstream of the bank of 8-bit bus registers and owns every `enable`/`load` line on the bus.

---
 rtl/bus_xfer_ctrl.sv | 116 +++++++++++
 tb/tb_bus_xfer_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer for the shared 8-bit bus: 2-entry request queue, IDLE/DRIVE/LATCH FSM.
// Optional bus snoop register enabled by defining BUS_SNOOP_EN.
module bus_xfer_ctrl #(
  parameter int NREG  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_valid may be held with stable payload until then, req_ready depends only on state.
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_src,
  input  logic [SEL_W-1:0] req_dst,
  output logic             req_ready,
  output logic [NREG-1:0]  en,
  output logic [NREG-1:0]  load,
  output logic             done,
  output logic             err,
  output logic             busy,
`ifdef BUS_SNOOP_EN
  input  logic [7:0]       bus,
  output logic [7:0]       snoop_data,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [SEL_W:0]  NREG_W = (SEL_W + 1)'(NREG);
  localparam logic [NREG-1:0] ONE    = {{(NREG-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] cur_src, cur_dst, src_n, dst_n;
  logic [SEL_W-1:0] q_src [2];
  logic [SEL_W-1:0] q_dst [2];
  logic [1:0]       count, count_n, wr_idx;

  logic accept, req_ok, push, pop, q_pop, q_push;

  assign req_ready = (count < 2'd2);
  assign dbg_state = state;

  always_comb begin
    accept  = req_valid && req_ready;
    req_ok  = (req_src != req_dst) && ({1'b0, req_src} < NREG_W) && ({1'b0, req_dst} < NREG_W);
    push    = accept && req_ok;
    pop     = ((state == ST_IDLE) || (state == ST_LATCH)) && ((count != 2'd0) || push);
    // With an empty queue the incoming request is popped on the same edge it is pushed.
    q_pop   = pop && (count != 2'd0);
    q_push  = push && !(pop && (count == 2'd0));
    count_n = count + {1'b0, q_push} - {1'b0, q_pop};
    wr_idx  = count - {1'b0, q_pop};

    src_n = cur_src;
    dst_n = cur_dst;
    if (pop) begin
      src_n = (count != 2'd0) ? q_src[0] : req_src;
      dst_n = (count != 2'd0) ? q_dst[0] : req_dst;
    end

    state_n = state;
    case (state)
      ST_IDLE:  state_n = pop ? ST_DRIVE : ST_IDLE;
      ST_DRIVE: state_n = ST_LATCH;
      ST_LATCH: state_n = pop ? ST_DRIVE : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_src  <= '0;
      cur_dst  <= '0;
      q_src[0] <= '0;
      q_src[1] <= '0;
      q_dst[0] <= '0;
      q_dst[1] <= '0;
      count    <= 2'd0;
      en       <= '0;
      load     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= state_n;
      cur_src <= src_n;
      cur_dst <= dst_n;
      count   <= count_n;
      if (q_pop) begin
        q_src[0] <= q_src[1];
        q_dst[0] <= q_dst[1];
      end
      // Placed after the shift so a simultaneous push into slot 0 wins.
      if (q_push) begin
        q_src[wr_idx[0]] <= req_src;
        q_dst[wr_idx[0]] <= req_dst;
      end
      en   <= (state_n != ST_IDLE)  ? (ONE << src_n) : '0;
      load <= (state_n == ST_LATCH) ? (ONE << dst_n) : '0;
      done <= (state == ST_LATCH);
      err  <= accept && !req_ok;
      busy <= (state_n != ST_IDLE) || (count_n != 2'd0);
    end
  end

`ifdef BUS_SNOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 snoop_data <= 8'h00;
    else if (state == ST_LATCH) snoop_data <= bus;
  end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: driver pushes expected transfers/errors, a negedge monitor pops and compares.
// Snoop checks are compiled in when BUS_SNOOP_EN is defined.
module tb_bus_xfer_ctrl;
  localparam int NREG  = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [SEL_W-1:0] req_src = '0;
  logic [SEL_W-1:0] req_dst = '0;
  logic             req_ready;
  logic [NREG-1:0]  en, load;
  logic             done, err, busy;
  logic [1:0]       dbg_state;
`ifdef BUS_SNOOP_EN
  logic [7:0]       bus = 8'h00;
  logic [7:0]       snoop_data;
`endif

  bus_xfer_ctrl #(.NREG(NREG), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst), .req_ready(req_ready),
    .en(en), .load(load), .done(done), .err(err), .busy(busy),
`ifdef BUS_SNOOP_EN
    .bus(bus), .snoop_data(snoop_data),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [5:0] exp_q[$];
  logic       err_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc[$];
  bit   saw_stall = 1'b0;
  logic prev_latch = 1'b0;
  logic [NREG-1:0] prev_en = '0;
  logic [NREG-1:0] prev_load = '0;
  logic [NREG-1:0] one = 8'h01;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d);
    int waitc = 0;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      if (waitc > 0) saw_stall = 1'b1;
      if (s != d) exp_q.push_back({s, d});
      else        err_q.push_back(1'b1);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: samples at negedge, away from the active edge.
  always @(negedge clk) begin
    logic [5:0] e;
    cyc++;
    if (!rst_n) begin
      prev_latch = 1'b0;
      prev_en    = '0;
      prev_load  = '0;
    end else begin
      check("en_onehot0", 32'($onehot0(en)), 32'd1);
      check("load_onehot0", 32'($onehot0(load)), 32'd1);
      check("done_after_latch", 32'(done), 32'(prev_latch));
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (load != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'(load), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("latch_en", 32'(en), 32'(one << e[5:3]));
          check("latch_load", 32'(load), 32'(one << e[2:0]));
          check("drive_en", 32'(prev_en), 32'(en));
          check("drive_load", 32'(prev_load), 32'd0);
        end
      end
      if (err) begin
        if (err_q.size() == 0) check("unexpected_err", 32'(err), 32'd0);
        else                   check("err_expected", 32'(err_q.pop_front()), 32'd1);
      end
      prev_latch = (load != '0);
      prev_en    = en;
      prev_load  = load;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", 32'(en), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef BUS_SNOOP_EN
    check("rst_snoop", 32'(snoop_data), 32'h00);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);

    // Single transfer 2 -> 5, bus=0xA5 during LATCH
`ifdef BUS_SNOOP_EN
    bus = 8'hA5;
`endif
    send(3'd2, 3'd5);
    check("k1_en", 32'(en), 32'h04);
    check("k1_load", 32'(load), 32'h00);
    @(negedge clk);
    check("k2_en", 32'(en), 32'h04);
    check("k2_load", 32'(load), 32'h20);
    @(negedge clk);
    check("k3_done", 32'(done), 32'd1);
    check("k3_busy", 32'(busy), 32'd0);
    check("k3_en", 32'(en), 32'h00);
    check("k3_load", 32'(load), 32'h00);
`ifdef BUS_SNOOP_EN
    check("k3_snoop", 32'(snoop_data), 32'hA5);
    bus = 8'h3C;
    @(negedge clk);
    check("snoop_hold", 32'(snoop_data), 32'hA5);
`endif
    @(negedge clk);

    // Invalid requests: accepted, err pulse, no bus activity
    send(3'd3, 3'd3);
    check("inv1_err", 32'(err), 32'd1);
    check("inv1_busy", 32'(busy), 32'd0);
    check("inv1_en", 32'(en), 32'd0);
    send(3'd7, 3'd7);
    check("inv2_err", 32'(err), 32'd1);
    check("inv2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("inv_err_clear", 32'(err), 32'd0);
    check("inv_ready", 32'(req_ready), 32'd1);
    check("inv_load", 32'(load), 32'd0);

    // Back-to-back burst; the fourth queued request fills the queue and stalls the fifth
    done_cnt = 0;
    done_cyc.delete();
    saw_stall = 1'b0;
    send(3'd1, 3'd3);
    send(3'd4, 3'd0);
    send(3'd6, 3'd7);
    send(3'd2, 3'd6);
    send(3'd5, 3'd1);
    wait_idle();
    @(negedge clk);
    check("burst_done_cnt", 32'(done_cnt), 32'd5);
    check("burst_stall_seen", 32'(saw_stall), 32'd1);
    for (int i = 1; i < done_cyc.size(); i++)
      check("burst_done_gap", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);

    // Reset during LATCH of 0 -> 1
    send(3'd0, 3'd1);
    @(negedge clk);
    #2;
    check("mid_latch_seen", 32'(load), 32'h02);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(en), 32'd0);
    check("mid_rst_load", 32'(load), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(req_ready), 32'd1);
    check("mid_rel_busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
    end

    // Random request stream with idle gaps
    for (int i = 0; i < 250; i++) begin
      send(3'($urandom_range(0, NREG-1)), 3'($urandom_range(0, NREG-1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_err_q_empty", 32'(err_q.size()), 32'd0);
    check("final_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
